pixel_chain_readout: RTL and testbench

PIXEL_CHAIN_READOUT -- requirements
Module: pixel_chain_readout

---
 rtl/pixel_readout_pkg.sv | 25 ++
 rtl/pixel_chain_readout_deser.sv | 49 ++++
 rtl/pixel_chain_readout.sv | 205 ++++++++++++++++++++
 tb/tb_pixel_chain_readout.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_readout_pkg.sv
// -----------------------------------------------------------------------------
// pixel_readout_pkg
// Shared types and default sizing for the pixel chain readout block.
//   readoutState_e : frame sequencer states
//   NPIX_DEF       : pixels per serial chain
//   CNT_W_DEF      : counter bits per pixel per chain (A and B)
//   GAP_CYC_DEF    : shutter-low settling cycles before shifting
//   ACQ_W          : width of the acquisition-length request
// -----------------------------------------------------------------------------
package pixel_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DRAIN = 3'd4
  } readoutState_e;

  localparam int NPIX_DEF    = 16;
  localparam int CNT_W_DEF   = 12;
  localparam int GAP_CYC_DEF = 2;
  localparam int ACQ_W       = 16;

endpackage

// File: rtl/pixel_chain_readout_deser.sv
// -----------------------------------------------------------------------------
// serial_deser
// Collects CNT_W serial bits (MSB first) from one chain tail into a word.
//   clk     : chain read clock (rising edge)
//   reset   : synchronous, active-high
//   shiftEn : a chain shift happens on this edge; sample serIn
//   serIn   : chain tail bit
//   word    : assembled word, complete on the cycle load is high
//   load    : this enabled edge carries the last bit of a word
// -----------------------------------------------------------------------------
module serial_deser
  import pixel_readout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shiftEn,
  input  logic             serIn,
  output logic [CNT_W-1:0] word,
  output logic             load
);

  localparam int BIT_W = $clog2(CNT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);

  logic [CNT_W-2:0] shift_r;
  logic [BIT_W-1:0] bitCnt_r;

  // The in-flight bit is appended combinationally so the full word can be
  // captured on the same edge that delivers its last bit.
  assign word = {shift_r, serIn};
  assign load = shiftEn && (bitCnt_r == LAST_BIT);

  // Shift register and bit counter; the counter wraps at every word boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r  <= {(CNT_W-1){1'b0}};
      bitCnt_r <= {BIT_W{1'b0}};
    end else if (shiftEn) begin
      shift_r  <= word[CNT_W-2:0];
      bitCnt_r <= load ? {BIT_W{1'b0}} : (bitCnt_r + BIT_W'(1));
    end else begin
      shift_r  <= shift_r;
      bitCnt_r <= bitCnt_r;
    end
  end

endmodule

// File: rtl/pixel_chain_readout.sv
// -----------------------------------------------------------------------------
// pixel_chain_readout
// Runs one acquisition (shutter window) followed by a serial readout of a
// digit_front_end pixel chain, presenting one pixel's A/B counters per word
// on a valid/ready interface.
//   clk_read, reset      : clock and synchronous active-high reset
//   start, acqLen        : frame request and shutter length (cycles)
//   shutter              : registered shutter to all pixels
//   chainClkEn           : one chain shift per enabled cycle
//   SerInA/B, SerOutA/B  : chain head (held 0) and chain tail
//   dataA/B, pixIdx,
//   dataValid, dataLast,
//   dataReady            : word stream, pixIdx 0 = chain tail
//   busy, done           : frame in progress / one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module pixel_chain_readout
  import pixel_readout_pkg::*;
#(
  parameter int NPIX    = NPIX_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF,
  localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             clk_read,
  input  logic             reset,
  input  logic             start,
  input  logic [ACQ_W-1:0] acqLen,
  output logic             shutter,
  output logic             chainClkEn,
  output logic             SerInA,
  output logic             SerInB,
  input  logic             SerOutA,
  input  logic             SerOutB,
  output logic [CNT_W-1:0] dataA,
  output logic [CNT_W-1:0] dataB,
  output logic [PIX_W-1:0] pixIdx,
  output logic             dataValid,
  output logic             dataLast,
  input  logic             dataReady,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] ACQ   = ST_ACQ;
  localparam logic [2:0] GAP   = ST_GAP;
  localparam logic [2:0] SHIFT = ST_SHIFT;
  localparam logic [2:0] DRAIN = ST_DRAIN;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

  logic [2:0]       state_r;
  logic [ACQ_W-1:0] acqCnt_r;
  logic [GAP_W-1:0] gapCnt_r;
  logic [PIX_W-1:0] pixCnt_r;
  logic             shutter_r;
  logic             done_r;
  logic [CNT_W-1:0] dataA_r;
  logic [CNT_W-1:0] dataB_r;
  logic [PIX_W-1:0] pixIdx_r;
  logic             dataValid_r;
  logic             dataLast_r;

  logic [CNT_W-1:0] wordA_s;
  logic [CNT_W-1:0] wordB_s;
  logic             loadA_s;
  logic             loadB_s;
  logic             load_s;
  logic             shiftEn_s;
  logic             accept_s;

  // The chain only advances when the output register is free or being
  // emptied this cycle, so a stalled consumer never loses chain bits.
  assign shiftEn_s  = (state_r == SHIFT) && (!dataValid_r || dataReady);
  assign accept_s   = dataValid_r && dataReady;
  assign load_s     = loadA_s && loadB_s;

  assign chainClkEn = shiftEn_s;
  assign SerInA     = 1'b0;
  assign SerInB     = 1'b0;
  assign shutter    = shutter_r;
  assign busy       = (state_r != IDLE);
  assign done       = done_r;
  assign dataA      = dataA_r;
  assign dataB      = dataB_r;
  assign pixIdx     = pixIdx_r;
  assign dataValid  = dataValid_r;
  assign dataLast   = dataLast_r;

  serial_deser #(.CNT_W(CNT_W)) u_deserA (
    .clk     (clk_read),
    .reset   (reset),
    .shiftEn (shiftEn_s),
    .serIn   (SerOutA),
    .word    (wordA_s),
    .load    (loadA_s)
  );

  serial_deser #(.CNT_W(CNT_W)) u_deserB (
    .clk     (clk_read),
    .reset   (reset),
    .shiftEn (shiftEn_s),
    .serIn   (SerOutB),
    .word    (wordB_s),
    .load    (loadB_s)
  );

  // Frame sequencer: shutter window, settling gap, shifting, final drain.
  always_ff @(posedge clk_read) begin
    if (reset) begin
      state_r   <= IDLE;
      acqCnt_r  <= {ACQ_W{1'b0}};
      gapCnt_r  <= {GAP_W{1'b0}};
      pixCnt_r  <= {PIX_W{1'b0}};
      shutter_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (acqLen != {ACQ_W{1'b0}}) begin
              // Counter holds remaining high cycles after the first one.
              state_r   <= ACQ;
              shutter_r <= 1'b1;
              acqCnt_r  <= acqLen - ACQ_W'(1);
            end else begin
              state_r  <= GAP;
              gapCnt_r <= GAP_LOAD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACQ: begin
          if (acqCnt_r == {ACQ_W{1'b0}}) begin
            state_r   <= GAP;
            shutter_r <= 1'b0;
            gapCnt_r  <= GAP_LOAD;
          end else begin
            acqCnt_r <= acqCnt_r - ACQ_W'(1);
          end
        end
        GAP: begin
          if (gapCnt_r == {GAP_W{1'b0}}) begin
            state_r <= SHIFT;
          end else begin
            gapCnt_r <= gapCnt_r - GAP_W'(1);
          end
        end
        SHIFT: begin
          if (load_s) begin
            if (pixCnt_r == LAST_PIX) begin
              pixCnt_r <= {PIX_W{1'b0}};
              state_r  <= DRAIN;
            end else begin
              pixCnt_r <= pixCnt_r + PIX_W'(1);
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        DRAIN: begin
          if (accept_s) begin
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r   <= IDLE;
          shutter_r <= 1'b0;
        end
      endcase
    end
  end

  // Output word register; a load on the accepting edge replaces the word
  // directly, so back-to-back words need no idle cycle.
  always_ff @(posedge clk_read) begin
    if (reset) begin
      dataA_r     <= {CNT_W{1'b0}};
      dataB_r     <= {CNT_W{1'b0}};
      pixIdx_r    <= {PIX_W{1'b0}};
      dataValid_r <= 1'b0;
      dataLast_r  <= 1'b0;
    end else if (load_s) begin
      dataA_r     <= wordA_s;
      dataB_r     <= wordB_s;
      pixIdx_r    <= pixCnt_r;
      dataValid_r <= 1'b1;
      dataLast_r  <= (pixCnt_r == LAST_PIX);
    end else if (accept_s) begin
      dataValid_r <= 1'b0;
      dataLast_r  <= 1'b0;
    end else begin
      dataValid_r <= dataValid_r;
      dataLast_r  <= dataLast_r;
    end
  end

endmodule

// File: tb/tb_pixel_chain_readout.sv
// -----------------------------------------------------------------------------
// tb_pixel_chain_readout
// Drives frames into pixel_chain_readout against a behavioural chain of
// NPIX pixels and compares the word stream and frame timing with values
// derived from the pixel contents and the frame rules.
// -----------------------------------------------------------------------------
module tb_pixel_chain_readout;

  localparam int NPIX    = 4;
  localparam int CNT_W   = 4;
  localparam int GAP_CYC = 2;
  localparam int TOT     = NPIX * CNT_W;
  localparam int PIX_W   = 2;

  typedef struct {
    logic [CNT_W-1:0] a;
    logic [CNT_W-1:0] b;
    logic [PIX_W-1:0] idx;
    logic             last;
  } word_t;

  logic             clk_read = 1'b0;
  logic             reset;
  logic             start;
  logic [15:0]      acqLen;
  logic             shutter;
  logic             chainClkEn;
  logic             SerInA;
  logic             SerInB;
  logic             SerOutA;
  logic             SerOutB;
  logic [CNT_W-1:0] dataA;
  logic [CNT_W-1:0] dataB;
  logic [PIX_W-1:0] pixIdx;
  logic             dataValid;
  logic             dataLast;
  logic             dataReady;
  logic             busy;
  logic             done;

  logic [TOT-1:0] chainA;
  logic [TOT-1:0] chainB;

  int tests = 0;
  int fails = 0;

  int readyMode;
  int stallCnt;
  int frameCyc;
  int enCnt, firstEn, shutCnt, firstShut, lastShut;
  int ruleErr, holdErr, stallObs, doneCnt, doneCyc;
  bit enSeen, prevStall, prevLast;
  logic [CNT_W-1:0] prevA, prevB;
  logic [PIX_W-1:0] prevIdx;
  word_t expQ[$];
  word_t obsQ[$];

  always #5 clk_read = ~clk_read;

  assign SerOutA = chainA[TOT-1];
  assign SerOutB = chainB[TOT-1];

  pixel_chain_readout #(.NPIX(NPIX), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
    .clk_read   (clk_read),
    .reset      (reset),
    .start      (start),
    .acqLen     (acqLen),
    .shutter    (shutter),
    .chainClkEn (chainClkEn),
    .SerInA     (SerInA),
    .SerInB     (SerInB),
    .SerOutA    (SerOutA),
    .SerOutB    (SerOutB),
    .dataA      (dataA),
    .dataB      (dataB),
    .pixIdx     (pixIdx),
    .dataValid  (dataValid),
    .dataLast   (dataLast),
    .dataReady  (dataReady),
    .busy       (busy),
    .done       (done)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: shift the chain model after the edge, drive ready, then
  // sample everything at the falling edge.
  task automatic tick();
    @(posedge clk_read);
    #1;
    if (enSeen) begin
      chainA = {chainA[TOT-2:0], SerInA};
      chainB = {chainB[TOT-2:0], SerInB};
    end
    case (readyMode)
      0: dataReady = 1'b1;
      1: dataReady = ($urandom_range(0, 3) != 0);
      default: begin
        if (dataValid && stallCnt < 5) begin
          dataReady = 1'b0;
          stallCnt++;
        end else begin
          dataReady = 1'b1;
        end
      end
    endcase
    @(negedge clk_read);
    frameCyc++;
    enSeen = chainClkEn;
    if (chainClkEn) begin
      enCnt++;
      if (firstEn < 0) firstEn = frameCyc;
    end
    if (shutter) begin
      shutCnt++;
      if (firstShut < 0) firstShut = frameCyc;
      lastShut = frameCyc;
    end
    if (shutter && chainClkEn) ruleErr++;
    if (chainClkEn && dataValid && !dataReady) ruleErr++;
    if (prevStall && (!dataValid || dataA != prevA || dataB != prevB ||
                      pixIdx != prevIdx || dataLast != prevLast)) holdErr++;
    if (dataValid && !dataReady) stallObs++;
    prevStall = dataValid && !dataReady;
    prevA = dataA; prevB = dataB; prevIdx = pixIdx; prevLast = dataLast;
    if (dataValid && dataReady) obsQ.push_back('{dataA, dataB, pixIdx, dataLast});
    if (done) begin
      doneCnt++;
      doneCyc = frameCyc;
    end
  endtask

  task automatic clearStats();
    enCnt = 0; firstEn = -1; shutCnt = 0; firstShut = -1; lastShut = -1;
    ruleErr = 0; holdErr = 0; stallObs = 0; doneCnt = 0; doneCyc = -1;
    prevStall = 1'b0; stallCnt = 0;
    expQ.delete();
    obsQ.delete();
  endtask

  // Fill the chain: pixel 0 sits at the tail, each counter MSB first.
  task automatic loadChain(input bit useFixed);
    logic [CNT_W-1:0] va, vb;
    for (int p = 0; p < NPIX; p++) begin
      if (useFixed) begin
        case (p)
          0: begin va = 4'd3;  vb = 4'd0; end
          1: begin va = 4'd5;  vb = 4'd1; end
          2: begin va = 4'd9;  vb = 4'd2; end
          default: begin va = 4'd15; vb = 4'd4; end
        endcase
      end else begin
        va = CNT_W'($urandom);
        vb = CNT_W'($urandom);
      end
      chainA[TOT-1-p*CNT_W -: CNT_W] = va;
      chainB[TOT-1-p*CNT_W -: CNT_W] = vb;
      expQ.push_back('{va, vb, PIX_W'(p), (p == NPIX-1)});
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkVal({pfx, "_shutter"}, shutter, 0);
    checkVal({pfx, "_clkEn"}, chainClkEn, 0);
    checkVal({pfx, "_valid"}, dataValid, 0);
    checkVal({pfx, "_last"}, dataLast, 0);
    checkVal({pfx, "_busy"}, busy, 0);
    checkVal({pfx, "_done"}, done, 0);
    checkVal({pfx, "_dataA"}, dataA, 0);
    checkVal({pfx, "_dataB"}, dataB, 0);
    checkVal({pfx, "_pixIdx"}, pixIdx, 0);
  endtask

  // Run one full frame and check it against the frame rules.
  task automatic runFrame(input string nm, input int len, input int mode,
                          input bit extra, input bit useFixed);
    int guard;
    bit busy1;
    word_t e, o;
    clearStats();
    readyMode = mode;
    loadChain(useFixed);
    acqLen = 16'(len);
    start = 1'b1;
    frameCyc = 0;
    tick();
    start = 1'b0;
    acqLen = 16'($urandom_range(1, 60));
    busy1 = busy;
    guard = 0;
    while (doneCnt == 0 && guard < 600) begin
      tick();
      guard++;
      if (extra && (frameCyc == 2 || frameCyc == len + GAP_CYC + 4)) begin
        start = 1'b1;
        acqLen = 16'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkVal({nm, "_doneSeen"}, (doneCnt != 0), 1);
    checkVal({nm, "_busyDuring"}, busy1, 1);
    checkVal({nm, "_busyAtDone"}, busy, 0);
    for (int i = 0; i < 10; i++) tick();
    checkVal({nm, "_doneOnce"}, doneCnt, 1);
    checkVal({nm, "_idleAfter"}, busy, 0);
    checkVal({nm, "_shutCycles"}, shutCnt, len);
    if (len > 0) begin
      checkVal({nm, "_shutFirst"}, firstShut, 1);
      checkVal({nm, "_shutLast"}, lastShut, len);
    end
    checkVal({nm, "_enCycles"}, enCnt, TOT);
    checkVal({nm, "_firstEn"}, firstEn, len + GAP_CYC + 1);
    checkVal({nm, "_rules"}, ruleErr, 0);
    checkVal({nm, "_hold"}, holdErr, 0);
    if (mode == 0) checkVal({nm, "_doneCyc"}, doneCyc, len + GAP_CYC + TOT + 2);
    if (mode == 2) checkVal({nm, "_stallCycles"}, stallObs, 5);
    checkVal({nm, "_wordCount"}, obsQ.size(), NPIX);
    for (int p = 0; p < NPIX; p++) begin
      e = expQ[p];
      if (p < obsQ.size()) begin
        o = obsQ[p];
        checkVal($sformatf("%s_w%0d_A", nm, p), o.a, e.a);
        checkVal($sformatf("%s_w%0d_B", nm, p), o.b, e.b);
        checkVal($sformatf("%s_w%0d_idx", nm, p), o.idx, e.idx);
        checkVal($sformatf("%s_w%0d_last", nm, p), o.last, e.last);
      end
    end
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    start = 1'b0;
    acqLen = 16'd0;
    dataReady = 1'b1;
    readyMode = 0;
    chainA = '0;
    chainB = '0;
    enSeen = 1'b0;
    frameCyc = 0;
    clearStats();
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    checkResetOutputs("rst");

    runFrame("basic", 10, 0, 1'b0, 1'b1);
    runFrame("zeroAcq", 0, 0, 1'b0, 1'b0);
    runFrame("stall", 4, 2, 1'b0, 1'b0);
    runFrame("ignoreStart", 6, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      runFrame($sformatf("rand%0d", k), $urandom_range(0, 12), 1, 1'b0, 1'b0);
    end

    // Abort a frame part-way through shifting.
    clearStats();
    readyMode = 0;
    loadChain(1'b0);
    acqLen = 16'd2;
    start = 1'b1;
    frameCyc = 0;
    tick();
    start = 1'b0;
    guard = 0;
    while (enCnt < 6 && guard < 200) begin
      tick();
      guard++;
    end
    checkVal("abort_reach6", (enCnt >= 6), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkResetOutputs("abort");
    for (int i = 0; i < 5; i++) tick();
    checkVal("abort_noDone", doneCnt, 0);
    checkVal("abort_stayIdle", busy, 0);

    runFrame("afterAbort", 3, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
